// File: rtl/stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stage_sequencer                                              |
// | Description : N-stage instruction sequencer with stage skipping, halt,     |
// |               stage watchdog, misaligned-jump fault, PC and instret.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module stage_sequencer #(
  parameter int              NUM_STAGES     = 5,
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR   = XLEN'(32'h0001_0000),
  parameter int              TIMEOUT_CYCLES = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_STAGES-1:0]         stage_complete,
  input  logic [NUM_STAGES-1:0]         stage_skip,
  input  logic                          jump_enable,
  input  logic [XLEN-1:0]               jump_target,
  input  logic                          halt_req,
  output logic [NUM_STAGES-1:0]         stage_enable,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic                          stage_entry,
  output logic                          retire,
  output logic [XLEN-1:0]               pc,
  output logic [63:0]                   instret,
  output logic                          halted,
  output logic                          fault,
  output logic [1:0]                    fault_cause
);

  localparam int                  IW              = $clog2(NUM_STAGES);
  localparam logic [IW-1:0]       C_LAST          = IW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] C_ONE         = NUM_STAGES'(1);
  localparam logic [1:0]          C_CAUSE_JUMP    = 2'b01;
  localparam logic [1:0]          C_CAUSE_TIMEOUT = 2'b10;
  localparam bit                  C_WD_EN         = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0]         C_WD_LAST       = C_WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_stage;
  logic [NUM_STAGES-1:0]   r_enable;
  logic                    r_entry;
  logic                    r_retire;
  logic [XLEN-1:0]         r_pc;
  logic [63:0]             r_instret;
  logic                    r_fault;
  logic [1:0]              r_cause;
  logic [31:0]             r_wdog;

  logic [IW-1:0]           w_next;
  logic                    w_found;
  logic                    w_cur_done;
  logic                    w_misaligned;

  // First non-skipped stage after the current one; the last stage is the fallback.
  always_comb begin
    w_next  = C_LAST;
    w_found = 1'b0;
    for (int t = 1; t < NUM_STAGES - 1; t++) begin
      if (!w_found && (IW'(t) > r_stage) && !stage_skip[t]) begin
        w_next  = IW'(t);
        w_found = 1'b1;
      end
    end
  end

  assign w_cur_done   = stage_complete[r_stage];
  assign w_misaligned = jump_enable && (jump_target[1:0] != 2'b00);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_stage   <= '0;
      r_enable  <= C_ONE;
      r_entry   <= 1'b1;
      r_retire  <= 1'b0;
      r_pc      <= RESET_VECTOR;
      r_instret <= '0;
      r_fault   <= 1'b0;
      r_cause   <= 2'b00;
      r_wdog    <= '0;
    end else begin
      r_entry  <= 1'b0;
      r_retire <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_cur_done) begin
            r_wdog <= '0;
            if (r_stage == C_LAST) begin
              r_stage <= '0;
              if (w_misaligned) begin
                r_fault  <= 1'b1;
                r_cause  <= C_CAUSE_JUMP;
                r_state  <= ST_HALTED;
                r_enable <= '0;
              end else begin
                r_retire  <= 1'b1;
                r_instret <= r_instret + 64'd1;
                r_pc      <= jump_enable ? jump_target : r_pc + XLEN'(4);
                if (halt_req) begin
                  r_state  <= ST_HALTED;
                  r_enable <= '0;
                end else begin
                  r_enable <= C_ONE;
                  r_entry  <= 1'b1;
                end
              end
            end else begin
              r_stage  <= w_next;
              r_enable <= C_ONE << w_next;
              r_entry  <= 1'b1;
            end
          end else if (C_WD_EN && (r_wdog == C_WD_LAST)) begin
            r_fault  <= 1'b1;
            r_cause  <= C_CAUSE_TIMEOUT;
            r_state  <= ST_HALTED;
            r_enable <= '0;
            r_stage  <= '0;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end
        ST_HALTED: begin
          // A fault halt is only left through reset.
          if (!r_fault && !halt_req) begin
            r_state  <= ST_RUN;
            r_stage  <= '0;
            r_enable <= C_ONE;
            r_entry  <= 1'b1;
            r_wdog   <= '0;
          end
        end
        default: begin
          r_state <= ST_HALTED;
        end
      endcase
    end
  end

  assign stage_enable = r_enable;
  assign stage_idx    = r_stage;
  assign stage_entry  = r_entry;
  assign retire       = r_retire;
  assign pc           = r_pc;
  assign instret      = r_instret;
  assign halted       = (r_state == ST_HALTED);
  assign fault        = r_fault;
  assign fault_cause  = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stage_sequencer                                           |
// | Description : Scoreboard bench for stage_sequencer with a reference model. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_stage_sequencer;

  localparam int          N  = 5;
  localparam int          TO = 8;
  localparam logic [31:0] RV = 32'h0001_0000;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] stage_complete;
  logic [N-1:0] stage_skip;
  logic         jump_enable;
  logic [31:0]  jump_target;
  logic         halt_req;
  logic [N-1:0] stage_enable;
  logic [2:0]   stage_idx;
  logic         stage_entry;
  logic         retire;
  logic [31:0]  pc;
  logic [63:0]  instret;
  logic         halted;
  logic         fault;
  logic [1:0]   fault_cause;

  stage_sequencer #(
    .NUM_STAGES    (N),
    .XLEN          (32),
    .RESET_VECTOR  (RV),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stage_complete(stage_complete),
    .stage_skip    (stage_skip),
    .jump_enable   (jump_enable),
    .jump_target   (jump_target),
    .halt_req      (halt_req),
    .stage_enable  (stage_enable),
    .stage_idx     (stage_idx),
    .stage_entry   (stage_entry),
    .retire        (retire),
    .pc            (pc),
    .instret       (instret),
    .halted        (halted),
    .fault         (fault),
    .fault_cause   (fault_cause)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [N-1:0] en;
    logic [2:0]   idx;
    logic         entry;
    logic         ret;
    logic [31:0]  pc;
    logic [63:0]  instret;
    logic         halted;
    logic         fault;
    logic [1:0]   cause;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] instret;
  } ret_t;

  exp_t exp_q[$];
  ret_t ret_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural view of the sequencer.
  int          m_stage;
  int          m_cyc;
  bit          m_halted, m_fault, m_entry, m_retire;
  logic [1:0]  m_cause;
  logic [31:0] m_pc;
  logic [63:0] m_instret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input logic [N-1:0] cmp, input logic [N-1:0] skp,
                       input bit je, input logic [31:0] jt, input bit hr);
    int t;
    m_retire = 0;
    m_entry  = 0;
    if (rst) begin
      m_stage = 0; m_cyc = 0; m_halted = 0; m_fault = 0; m_cause = 2'b00;
      m_pc = RV; m_instret = 64'd0; m_entry = 1;
    end else if (m_halted) begin
      if (!m_fault && !hr) begin
        m_halted = 0; m_stage = 0; m_cyc = 0; m_entry = 1;
      end
    end else if (cmp[m_stage]) begin
      if (m_stage == N - 1) begin
        m_stage = 0;
        m_cyc   = 0;
        if (je && (jt % 4) != 0) begin
          m_fault = 1; m_cause = 2'b01; m_halted = 1;
        end else begin
          m_retire  = 1;
          m_instret = m_instret + 1;
          m_pc      = je ? jt : m_pc + 4;
          ret_q.push_back('{pc: m_pc, instret: m_instret});
          if (hr) m_halted = 1;
          else    m_entry  = 1;
        end
      end else begin
        t = m_stage + 1;
        while (t < N - 1 && skp[t]) t++;
        m_stage = t;
        m_cyc   = 0;
        m_entry = 1;
      end
    end else begin
      m_cyc++;
      if (TO > 0 && m_cyc >= TO) begin
        m_fault = 1; m_cause = 2'b10; m_halted = 1; m_stage = 0;
      end
    end
  endtask

  task automatic step(input bit rst, input logic [N-1:0] cmp, input logic [N-1:0] skp,
                      input bit je, input logic [31:0] jt, input bit hr);
    exp_t e;
    reset          = rst;
    stage_complete = cmp;
    stage_skip     = skp;
    jump_enable    = je;
    jump_target    = jt;
    halt_req       = hr;
    model(rst, cmp, skp, je, jt, hr);
    e.en      = m_halted ? '0 : N'(1 << m_stage);
    e.idx     = 3'(m_stage);
    e.entry   = m_entry;
    e.ret     = m_retire;
    e.pc      = m_pc;
    e.instret = m_instret;
    e.halted  = m_halted;
    e.fault   = m_fault;
    e.cause   = m_cause;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: compares every registered output after each active edge.
  initial begin
    exp_t e;
    ret_t r;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stage_enable", 64'(stage_enable), 64'(e.en));
        chk("stage_idx",    64'(stage_idx),    64'(e.idx));
        chk("retire",       64'(retire),       64'(e.ret));
        chk("pc",           64'(pc),           64'(e.pc));
        chk("instret",      instret,           e.instret);
        chk("halted",       64'(halted),       64'(e.halted));
        chk("fault",        64'(fault),        64'(e.fault));
        chk("fault_cause",  64'(fault_cause),  64'(e.cause));
        if (!e.halted) chk("stage_entry", 64'(stage_entry), 64'(e.entry));
      end
      if (retire === 1'b1) begin
        if (ret_q.size() == 0) begin
          chk("unexpected_retire", 64'd1, 64'd0);
        end else begin
          r = ret_q.pop_front();
          chk("retire_pc",      64'(pc), 64'(r.pc));
          chk("retire_instret", instret, r.instret);
        end
      end
    end
  end

  initial begin
    bit          armed;
    int          hcnt, fcnt, stall;
    logic [31:0] rv;
    logic [N-1:0] cmp;
    logic [1:0]  lo;

    repeat (3) step(1, '1, '0, 0, 32'd0, 0);
    repeat (15) step(0, '1, '0, 0, 32'd0, 0);
    repeat (9)  step(0, '1, 5'b01010, 0, 32'd0, 0);
    repeat (10) step(0, '1, '0, 1, 32'h0001_0100, 0);
    repeat (8)  step(0, '1, '0, 1, 32'h0001_0102, 0);
    repeat (3)  step(0, '1, '0, 0, 32'd0, 0);

    // Watchdog: stall stage 2 forever, then complete on the last allowed cycle.
    repeat (2) step(1, '1, '0, 0, 32'd0, 0);
    for (int i = 0; i < 20; i++) step(0, (m_stage == 2) ? 5'b11011 : 5'b11111, '0, 0, 32'd0, 0);
    repeat (2) step(1, '1, '0, 0, 32'd0, 0);
    for (int i = 0; i < 20; i++)
      step(0, (m_stage == 2 && m_cyc < TO - 1) ? 5'b11011 : 5'b11111, '0, 0, 32'd0, 0);

    // Halt raised in stage 2, held through commit and a few halted cycles.
    repeat (2) step(1, '1, '0, 0, 32'd0, 0);
    armed = 0;
    hcnt  = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_stage == 2 && !m_halted) armed = 1;
      if (m_halted) hcnt++;
      step(0, '1, '0, 0, 32'd0, armed && hcnt < 3);
    end

    // Reset in stage 3 after four retires.
    repeat (2) step(1, '1, '0, 0, 32'd0, 0);
    for (int i = 0; i < 60; i++) begin
      if (m_instret == 64'd4 && m_stage == 3) break;
      step(0, '1, '0, 0, 32'd0, 0);
    end
    step(1, '1, '0, 0, 32'd0, 0);
    repeat (6) step(0, '1, '0, 0, 32'd0, 0);

    fcnt  = 0;
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      fcnt = m_fault ? fcnt + 1 : 0;
      if (stall == 0 && $urandom_range(0, 49) == 0) stall = $urandom_range(4, 12);
      cmp = N'($urandom) | N'($urandom);
      if (stall > 0) begin
        cmp   = '0;
        stall = stall - 1;
      end
      rv = $urandom;
      lo = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(($urandom_range(0, 299) == 0) || fcnt > 4, cmp, N'($urandom),
           $urandom_range(0, 3) == 0, {rv[31:2], lo}, $urandom_range(0, 9) == 0);
    end

    repeat (3) step(1, '1, '0, 0, 32'd0, 0);
    repeat (2) @(negedge clock);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("retire_queue_drained", 64'(ret_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
